// File: rtl/i2c_pkg.sv
// Shared state encoding and bus-level bit constants for the I2C target.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_LOAD,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } state_t;

   localparam logic BIT_ACK  = 1'b0;
   localparam logic BIT_NACK = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// Host-side handshake of the I2C target.
// rx_valid and tx_req are single-clk pulses with no back-pressure; tx_data is sampled in the tx_req cycle.
interface i2c_slave_if;
   import i2c_pkg::*;

   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic       busy;
   logic       stop_det;
   state_t     state;

   modport slave  (input tx_data, output rx_data, rx_valid, tx_req, busy, stop_det, state);
   modport master (output tx_data, input rx_data, rx_valid, tx_req, busy, stop_det, state);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_cond,
   output logic stop_cond
);
   // [0],[1] are the synchroniser, [2] is the history flop; all reset to the idle-bus level
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl};
         sda_q <= {sda_q[1:0], sda};
      end
   end

   assign sda_s      = sda_q[1];
   assign scl_rise   =  scl_q[1] & ~scl_q[2];
   assign scl_fall   = ~scl_q[1] &  scl_q[2];
   assign start_cond =  scl_q[1] & ~sda_q[1] &  sda_q[2];
   assign stop_cond  =  scl_q[1] &  sda_q[1] & ~sda_q[2];
endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, write-byte reception and read-byte return on an open-drain SDA.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SCL,
   inout  wire        SDA,
   i2c_slave_if.slave host
);
   logic       sda_s, scl_rise, scl_fall, start_cond, stop_cond;
   state_t     state, state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] shreg, shreg_n, rx_q, rx_n;
   logic       rw, rw_n, sda_low, sda_low_n;
   logic       rx_valid_q, rx_valid_n, tx_req_q, tx_req_n;
   logic       busy_q, busy_n, stop_q, stop_n;

   i2c_bus_sync u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl        (SCL),
      .sda        (SDA),
      .sda_s      (sda_s),
      .scl_rise   (scl_rise),
      .scl_fall   (scl_fall),
      .start_cond (start_cond),
      .stop_cond  (stop_cond)
   );

   // sda_low is an async-reset flop, so reset releases the line without a clk edge
   assign SDA = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         rw         <= RW_WRITE;
         sda_low    <= 1'b0;
         rx_q       <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         rw         <= rw_n;
         sda_low    <= sda_low_n;
         rx_q       <= rx_n;
         rx_valid_q <= rx_valid_n;
         tx_req_q   <= tx_req_n;
         busy_q     <= busy_n;
         stop_q     <= stop_n;
      end
   end

   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      rw_n       = rw;
      sda_low_n  = sda_low;
      rx_n       = rx_q;
      rx_valid_n = 1'b0;
      tx_req_n   = 1'b0;
      busy_n     = busy_q;
      stop_n     = 1'b0;
      if (stop_cond) begin
         state_n   = IDLE;
         bit_cnt_n = 3'd0;
         sda_low_n = 1'b0;
         busy_n    = 1'b0;
         stop_n    = 1'b1;
      end else if (start_cond) begin
         state_n   = ADDR;
         bit_cnt_n = 3'd0;
         sda_low_n = 1'b0;
         busy_n    = 1'b0;
      end else begin
         unique case (state)
            ADDR: if (scl_rise) begin
               shreg_n   = {shreg[6:0], sda_s};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (shreg[6:0] == SLAVE_ADDR) begin
                     state_n = ADDR_ACK;
                     rw_n    = sda_s;
                     busy_n  = 1'b1;
                  end else begin
                     state_n = WAIT_STOP;
                  end
               end
            end
            // First fall starts the ACK; a read leaves on the ACK's rising edge so the
            // ACK is replaced by the first data bit at the following fall.
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_low) begin
                     sda_low_n = 1'b1;
                  end else if (rw == RW_WRITE) begin
                     sda_low_n = 1'b0;
                     state_n   = WR_DATA;
                  end
               end else if (scl_rise && sda_low && rw == RW_READ) begin
                  state_n  = RD_LOAD;
                  tx_req_n = 1'b1;
               end
            end
            WR_DATA: if (scl_rise) begin
               shreg_n   = {shreg[6:0], sda_s};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rx_n       = {shreg[6:0], sda_s};
                  rx_valid_n = 1'b1;
                  state_n    = WR_ACK;
               end
            end
            WR_ACK: if (scl_fall) begin
               if (!sda_low) begin
                  sda_low_n = 1'b1;
               end else begin
                  sda_low_n = 1'b0;
                  state_n   = WR_DATA;
               end
            end
            // Entered on an SCL rise; the clk ratio keeps the next fall clear of the tx_req cycle
            RD_LOAD: begin
               if (tx_req_q) begin
                  shreg_n = host.tx_data;
               end else if (scl_fall) begin
                  sda_low_n = ~shreg[7];
                  shreg_n   = {shreg[6:0], 1'b0};
                  state_n   = RD_DATA;
               end
            end
            RD_DATA: if (scl_fall) begin
               if (bit_cnt == 3'd7) begin
                  sda_low_n = 1'b0;
                  bit_cnt_n = 3'd0;
                  state_n   = RD_ACK;
               end else begin
                  sda_low_n = ~shreg[7];
                  shreg_n   = {shreg[6:0], 1'b0};
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end
            RD_ACK: if (scl_rise) begin
               unique case (sda_s)
                  BIT_ACK: begin
                     state_n  = RD_LOAD;
                     tx_req_n = 1'b1;
                  end
                  BIT_NACK: state_n = WAIT_STOP;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign host.rx_data  = rx_q;
   assign host.rx_valid = rx_valid_q;
   assign host.tx_req   = tx_req_q;
   assign host.busy     = busy_q;
   assign host.stop_det = stop_q;
   assign host.state    = state;
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, is the 7-bit bus address this target answers to.
REQ-002 clk  input  1  system clock; the only clock; frequency SHALL be at least 8x the SCL frequency.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 SCL  input  1  bus clock driven by the master; sampled, never driven.
REQ-005 SDA  inout  1  open-drain bus data; the block drives 0 or high-Z only, never 1.
REQ-006 tx_data  input  8  byte to return on a read transfer; sampled on the tx_req cycle.
REQ-007 rx_data  output  8  last byte written by the master; valid when rx_valid=1.
REQ-008 rx_valid  output  1  one-clk pulse per received write-data byte.
REQ-009 tx_req  output  1  one-clk pulse requesting the next read byte; tx_data is latched in that cycle.
REQ-010 busy  output  1  high from an address match until STOP or a repeated START.
REQ-011 stop_det  output  1  one-clk pulse on every detected STOP condition.

Function
REQ-012 SCL and SDA SHALL each pass through a 2-flop synchronizer plus one history flop; detected pin edges act 3 clk after the pin change.
REQ-013 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-014 START SHALL move the FSM to ADDR from any state, including mid-byte (repeated START), clear the bit counter and release SDA.
REQ-015 STOP SHALL move the FSM to IDLE from any state, release SDA, pulse stop_det and clear busy.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
REQ-017 Bits SHALL be sampled on SCL rising edges, MSB first; SDA drive changes SHALL occur only on SCL falling edges.
REQ-018 ADDR: shift 8 bits. On the 8th rising edge: if bits[7:1]==SLAVE_ADDR, go to ADDR_ACK and latch bit0 as the R/W flag (1=read). Otherwise go to WAIT_STOP with SDA released.
REQ-019 ADDR_ACK: drive SDA=0 from the next SCL falling edge through the following falling edge. Then go to WR_DATA if the flag is write, or RD_LOAD if read.
REQ-020 WR_DATA: shift 8 bits. On the 8th rising edge, set rx_data and pulse rx_valid in the same clk. Drive the ACK (SDA=0) for the next SCL low-high-low period (WR_ACK), then return to WR_DATA.
REQ-021 RD_LOAD: pulse tx_req for one clk, latch tx_data into the shift register, then go to RD_DATA; tx_req SHALL precede the first SCL falling edge of the data byte.
REQ-022 RD_DATA: on each SCL falling edge, drive SDA=0 when the current bit is 0 and release SDA when it is 1, for 8 bits. Release SDA on the falling edge after bit 0.
REQ-023 RD_ACK: sample SDA on the 9th rising edge. Master ACK (0) -> RD_LOAD; master NACK (1) -> WAIT_STOP.
REQ-024 WAIT_STOP: SDA released; ignore all bits until START or STOP.
REQ-025 The 3-bit bit counter wraps 7->0 only at the byte boundary; it never counts ACK bits.
REQ-026 Simultaneous STOP and a data-bit edge in the same clk: STOP SHALL win, with no rx_valid pulse for the partial byte.
REQ-027 A partial byte terminated by START/STOP SHALL be discarded silently.

Reset
REQ-028 While reset=0: FSM=IDLE, SDA released, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, stop_det=0, counter=0.
REQ-029 Synchronizer flops SHALL reset to 1 (idle bus) so that release does not produce a false START/STOP.
REQ-030 Assertion mid-transfer SHALL release SDA asynchronously, without waiting for clk.

Structure
REQ-031 The state enumeration and the ACK/NACK and R/W bit constants SHALL live in the shared package i2c_pkg.
REQ-032 Synchronizer, edge detection and START/STOP detection SHALL be one sub-module, i2c_bus_sync, instantiated once.

Verification
REQ-033 Write to 0x50: START, 8'hA0, 8'h3C, STOP -> ACK on both bytes, one rx_valid with rx_data=8'h3C, stop_det pulse, busy low afterwards.
REQ-034 Address mismatch: START, 8'hA2, 8'h55, STOP -> SDA never driven low by the slave, no rx_valid, busy stays 0.
REQ-035 Read 2 bytes: START, 8'hA1, tx_data=8'h96 then 8'h0F, master ACK then NACK, STOP -> bus shows 96 and 0F, exactly 2 tx_req pulses, SDA released after NACK.
REQ-036 Repeated START: START, 8'hA0, 8'h11, Sr, 8'hA1, read 1 byte with NACK, STOP -> rx_data=8'h11, R/W flag switches to read, one tx_req.
REQ-037 Abort: STOP after 4 bits of a write byte -> no rx_valid, FSM in IDLE, SDA released.
REQ-038 Reset low during RD_DATA while the slave drives SDA=0 -> SDA goes high-Z before the next clk edge, all outputs return to reset values.
